// File: rtl/dist_engine_arbiter_pkg.sv
// Shared constants and state encoding for the distance-engine arbiter.
package dist_engine_arbiter_pkg;

   localparam int          PT_W = 96;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_RESP = 2'd3
   } state_e;

endpackage

// File: rtl/dist_engine_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_vld
);

   localparam int              CNT_W = ID_W + 1;
   localparam logic [CNT_W-1:0] NUM_W = CNT_W'(NUM_REQ);

   logic [CNT_W-1:0] sum_w;
   logic [ID_W-1:0]  idx_w;

   // scan NUM_REQ slots starting at ptr, keep the first hit
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      sum_w     = '0;
      idx_w     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum_w = {1'b0, ptr} + CNT_W'(i);
         if (sum_w >= NUM_W) begin
            sum_w = sum_w - NUM_W;
         end
         idx_w = sum_w[ID_W-1:0];
         if (!grant_vld && req[idx_w]) begin
            grant_vld       = 1'b1;
            grant_idx       = idx_w;
            grant_oh[idx_w] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dist_engine_arbiter.sv
// Shares one 3-D distance engine among NUM_REQ requesters.
// Optional watchdog on the engine run phase: define DIST_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | engine held in reset, waiting for a request to grant
// HOLD    | operands latched, engine reset held RST_HOLD cycles
// RUN     | engine released, waiting for eng_done (first cycle ignored)
// RESP    | result presented until rsp_ready
module dist_engine_arbiter
   import dist_engine_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int RST_HOLD       = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    CLK2,
   input  logic                    RST,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*PT_W-1:0] req_pa,
   input  logic [NUM_REQ*PT_W-1:0] req_pb,
   output logic                    eng_rst_n,
   output logic [PT_W-1:0]         eng_pa,
   output logic [PT_W-1:0]         eng_pb,
   input  logic                    eng_done,
   input  logic [31:0]             eng_res,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             rsp_res,
   output logic                    rsp_err,
   output logic                    busy
);

   localparam int              HC_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     cur_id_q, cur_id_d;
   logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic                run_first_q, run_first_d;
   logic [PT_W-1:0]     eng_pa_q, eng_pa_d;
   logic [PT_W-1:0]     eng_pb_q, eng_pb_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [31:0]         rsp_res_q, rsp_res_d;

   logic [NUM_REQ-1:0]  grant_oh;
   logic [ID_W-1:0]     grant_idx;
   logic                grant_vld;
   logic                grant_go;
   logic                done_ok;
   logic                timeout;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   assign grant_go = (state_q == ST_IDLE) && grant_vld;
   // first RUN cycle may see a done left over from the previous launch
   assign done_ok  = (state_q == ST_RUN) && !run_first_q && eng_done;

`ifdef DIST_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            rsp_err_q, rsp_err_d;

   assign timeout = (state_q == ST_RUN) && !done_ok && (wd_cnt_q == '0);
   assign rsp_err = rsp_err_q;

   // watchdog down-counter, armed while the engine is held in HOLD
   always_comb begin
      wd_cnt_d  = wd_cnt_q;
      rsp_err_d = rsp_err_q;
      if (state_q == ST_HOLD) begin
         wd_cnt_d = WD_W'(TIMEOUT_CYCLES - 1);
      end else if ((state_q == ST_RUN) && (wd_cnt_q != '0)) begin
         wd_cnt_d = wd_cnt_q - 1'b1;
      end
      if (timeout) begin
         rsp_err_d = 1'b1;
      end else if ((state_q == ST_RESP) && rsp_ready) begin
         rsp_err_d = 1'b0;
      end
   end

   // watchdog registers
   always_ff @(posedge CLK2 or negedge RST) begin
      if (!RST) begin
         wd_cnt_q  <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end
`else
   assign timeout = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge CLK2 or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant_vld)            state_d = ST_HOLD;
         ST_HOLD: if (hold_cnt_q == '0)     state_d = ST_RUN;
         ST_RUN:  if (done_ok || timeout)   state_d = ST_RESP;
         ST_RESP: if (rsp_ready)            state_d = ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; req_ready is forced low while RST is asserted
   always_comb begin
      req_ready = '0;
      if ((state_q == ST_IDLE) && RST) begin
         req_ready = grant_oh;
      end
      eng_rst_n = (state_q == ST_RUN);
      busy      = (state_q != ST_IDLE);
   end

   // datapath next values: operand latch, pointer, hold timer, response
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cur_id_d    = cur_id_q;
      hold_cnt_d  = hold_cnt_q;
      run_first_d = (state_q == ST_HOLD);
      eng_pa_d    = eng_pa_q;
      eng_pb_d    = eng_pb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_res_d   = rsp_res_q;
      if (grant_go) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
               eng_pa_d = req_pa[i*PT_W +: PT_W];
               eng_pb_d = req_pb[i*PT_W +: PT_W];
            end
         end
         cur_id_d   = grant_idx;
         rr_ptr_d   = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
         hold_cnt_d = HC_W'(RST_HOLD - 1);
      end else if ((state_q == ST_HOLD) && (hold_cnt_q != '0)) begin
         hold_cnt_d = hold_cnt_q - 1'b1;
      end
      if (done_ok) begin
         rsp_valid_d = 1'b1;
         rsp_res_d   = eng_res;
         rsp_id_d    = cur_id_q;
      end else if (timeout) begin
         rsp_valid_d = 1'b1;
         rsp_res_d   = QNAN;
         rsp_id_d    = cur_id_q;
      end else if ((state_q == ST_RESP) && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // datapath registers
   always_ff @(posedge CLK2 or negedge RST) begin
      if (!RST) begin
         rr_ptr_q    <= '0;
         cur_id_q    <= '0;
         hold_cnt_q  <= '0;
         run_first_q <= 1'b0;
         eng_pa_q    <= '0;
         eng_pb_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_res_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cur_id_q    <= cur_id_d;
         hold_cnt_q  <= hold_cnt_d;
         run_first_q <= run_first_d;
         eng_pa_q    <= eng_pa_d;
         eng_pb_q    <= eng_pb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_res_q   <= rsp_res_d;
      end
   end

   assign eng_pa    = eng_pa_q;
   assign eng_pb    = eng_pb_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_res   = rsp_res_q;

endmodule
